// File: rtl/irq_coal_pkg.sv
// rtl/irq_coal_pkg.sv - shared state encoding, register map and popcount for irq_coalesce_ctrl
package irq_coal_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ASSERT  = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_e;

  localparam logic [5:0] REG_CTRL    = 6'd0;
  localparam logic [5:0] REG_TIMEOUT = 6'd1;
  localparam logic [5:0] REG_HOLDOFF = 6'd2;
  localparam logic [5:0] REG_STATUS  = 6'd3;
  localparam logic [5:0] REG_LIVE    = 6'd4;
  localparam logic [5:0] REG_ACK     = 6'd5;
  localparam logic [5:0] REG_STATE   = 6'd6;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + {5'b0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/irq_coal_regs.sv
// rtl/irq_coal_regs.sv - AHB-lite slave: config registers, read mux and ACK strobe
module irq_coal_regs import irq_coal_pkg::*; #(
  parameter int NSRC  = 16,
  parameter int CNT_W = 8,
  parameter int TMR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsel,
  input  logic             hready_in,
  input  logic [7:0]       haddr,
  input  logic [1:0]       htrans,
  input  logic             hwrite,
  input  logic [31:0]      hwdata,
  output logic [31:0]      hrdata,
  input  logic [NSRC-1:0]  status_i,
  input  logic [NSRC-1:0]  pend_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  state_e           state_i,
  output logic             enable_o,
  output logic [CNT_W-1:0] thr_o,
  output logic [TMR_W-1:0] timeout_o,
  output logic [TMR_W-1:0] holdoff_o,
  output logic             ack_o
);

  logic             addr_valid;
  logic [31:0]      rd_data;
  logic             wr_pend_q, wr_pend_d;
  logic [5:0]       wr_idx_q, wr_idx_d;
  logic             enable_q, enable_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic [TMR_W-1:0] timeout_q, timeout_d;
  logic [TMR_W-1:0] holdoff_q, holdoff_d;
  logic             ack_q, ack_d;
  logic [31:0]      hrdata_q, hrdata_d;
  logic             unused_bits;

  assign addr_valid  = hsel & hready_in & htrans[1];
  assign unused_bits = ^{hwdata, haddr[1:0], htrans[0]};

  always_comb begin
    rd_data = '0;
    case (haddr[7:2])
      REG_CTRL: begin
        rd_data[0]          = enable_q;
        rd_data[8 +: CNT_W] = thr_q;
      end
      REG_TIMEOUT: rd_data[TMR_W-1:0] = timeout_q;
      REG_HOLDOFF: rd_data[TMR_W-1:0] = holdoff_q;
      REG_STATUS:  rd_data[NSRC-1:0]  = status_i;
      REG_LIVE: begin
        rd_data[16 +: NSRC]  = pend_i;
        rd_data[CNT_W-1:0]   = cnt_i;
      end
      REG_STATE:   rd_data[1:0] = state_i;
      default:     rd_data = '0;
    endcase
  end

  always_comb begin
    wr_pend_d = addr_valid & hwrite;
    wr_idx_d  = addr_valid ? haddr[7:2] : wr_idx_q;
    enable_d  = enable_q;
    thr_d     = thr_q;
    timeout_d = timeout_q;
    holdoff_d = holdoff_q;
    ack_d     = 1'b0;
    hrdata_d  = (addr_valid && !hwrite) ? rd_data : hrdata_q;
    // Data phase: the address was captured on the previous cycle.
    if (wr_pend_q) begin
      case (wr_idx_q)
        REG_CTRL: begin
          enable_d = hwdata[0];
          thr_d    = hwdata[8 +: CNT_W];
        end
        REG_TIMEOUT: timeout_d = hwdata[TMR_W-1:0];
        REG_HOLDOFF: holdoff_d = hwdata[TMR_W-1:0];
        REG_ACK:     ack_d     = 1'b1;
        default:     ack_d     = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pend_q <= 1'b0;
      wr_idx_q  <= '0;
      enable_q  <= 1'b0;
      thr_q     <= '0;
      timeout_q <= '0;
      holdoff_q <= '0;
      ack_q     <= 1'b0;
      hrdata_q  <= '0;
    end else begin
      wr_pend_q <= wr_pend_d;
      wr_idx_q  <= wr_idx_d;
      enable_q  <= enable_d;
      thr_q     <= thr_d;
      timeout_q <= timeout_d;
      holdoff_q <= holdoff_d;
      ack_q     <= ack_d;
      hrdata_q  <= hrdata_d;
    end
  end

  assign hrdata    = hrdata_q;
  assign enable_o  = enable_q;
  assign thr_o     = thr_q;
  assign timeout_o = timeout_q;
  assign holdoff_o = holdoff_q;
  assign ack_o     = ack_q;

endmodule

// File: rtl/irq_coalesce_ctrl.sv
// rtl/irq_coalesce_ctrl.sv - interrupt moderation: event accumulator, timeout/holdoff timer and FSM
module irq_coalesce_ctrl import irq_coal_pkg::*; #(
  parameter int NSRC  = 16,
  parameter int CNT_W = 8,
  parameter int TMR_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hsel,
  input  logic            hready_in,
  input  logic [7:0]      haddr,
  input  logic [1:0]      htrans,
  input  logic            hwrite,
  input  logic [31:0]     hwdata,
  output logic [31:0]     hrdata,
  output logic [1:0]      hresp,
  output logic            hready,
  input  logic [NSRC-1:0] evt_in,
  input  logic            tick,
  output logic            irq_out
);

  logic             enable, ack;
  logic [CNT_W-1:0] thr, thr_eff;
  logic [TMR_W-1:0] timeout, holdoff, timer_dec;
  logic [NSRC-1:0]  evt_m;
  logic [5:0]       pc;
  logic [CNT_W+5:0] cnt_sum;
  logic [CNT_W-1:0] cnt_sat;

  state_e           state_q, state_d;
  logic [NSRC-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [NSRC-1:0]  status_q, status_d;
  logic             irq_q, irq_d;

  assign hresp  = 2'b00;
  assign hready = 1'b1;

  irq_coal_regs #(.NSRC(NSRC), .CNT_W(CNT_W), .TMR_W(TMR_W)) u_regs (
    .clk       (clk),
    .rst       (rst),
    .hsel      (hsel),
    .hready_in (hready_in),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .status_i  (status_q),
    .pend_i    (pend_q),
    .cnt_i     (cnt_q),
    .state_i   (state_q),
    .enable_o  (enable),
    .thr_o     (thr),
    .timeout_o (timeout),
    .holdoff_o (holdoff),
    .ack_o     (ack)
  );

  assign evt_m     = enable ? evt_in : '0;
  assign pc        = popcount(32'(evt_m));
  assign cnt_sum   = {6'b0, cnt_q} + {{CNT_W{1'b0}}, pc};
  assign cnt_sat   = (cnt_sum > {6'b0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  assign thr_eff   = (thr == '0) ? CNT_W'(1) : thr;
  assign timer_dec = (tick && timer_q != '0) ? timer_q - TMR_W'(1) : timer_q;

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q | evt_m;
    cnt_d    = cnt_sat;
    timer_d  = timer_q;
    status_d = status_q;
    irq_d    = irq_q;
    if (!enable) begin
      state_d  = ST_IDLE;
      pend_d   = '0;
      cnt_d    = '0;
      timer_d  = '0;
      status_d = '0;
      irq_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cnt_sat != '0) begin
            state_d = ST_COLLECT;
            timer_d = timeout;
          end
        end
        ST_COLLECT: begin
          // Events arriving on the firing cycle belong to this interrupt, not the next batch.
          if (cnt_q >= thr_eff || timer_q == '0) begin
            state_d  = ST_ASSERT;
            status_d = pend_q | evt_m;
            pend_d   = '0;
            cnt_d    = '0;
            irq_d    = 1'b1;
          end else begin
            timer_d = timer_dec;
          end
        end
        ST_ASSERT: begin
          if (ack) begin
            state_d  = ST_HOLDOFF;
            timer_d  = holdoff;
            status_d = '0;
            irq_d    = 1'b0;
          end
        end
        ST_HOLDOFF: begin
          if (timer_q == '0) begin
            state_d = (cnt_q != '0) ? ST_COLLECT : ST_IDLE;
            timer_d = (cnt_q != '0) ? timeout : timer_q;
          end else begin
            timer_d = timer_dec;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      status_q <= status_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_out = irq_q;

endmodule
